// File: rtl/cell_comm_tx_arbiter.sv
// Two-source AXIS packet arbiter feeding the Aurora TX: round-robin per packet,
// zero-latency passthrough, flush of the owner's packet when the channel drops.
// Optional statistics counters: define CELL_COMM_TX_STATS_EN.
module cell_comm_tx_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     auroraUserClk,
  input  logic                     auroraReset,
  input  logic                     channelUp,
  input  logic                     localTvalid,
  input  logic                     localTlast,
  input  logic [DATA_WIDTH-1:0]    localTdata,
  output logic                     localTready,
  input  logic                     fwdTvalid,
  input  logic                     fwdTlast,
  input  logic [DATA_WIDTH-1:0]    fwdTdata,
  output logic                     fwdTready,
  output logic                     txTvalid,
  output logic                     txTlast,
  output logic [DATA_WIDTH-1:0]    txTdata,
  input  logic                     txTready,
  output logic [1:0]               grant,
  output logic [COUNTER_WIDTH-1:0] localPktCount,
  output logic [COUNTER_WIDTH-1:0] fwdPktCount,
  output logic [COUNTER_WIDTH-1:0] flushCount
);

  typedef enum logic [1:0] {IDLE, LOCAL, FWD, FLUSH} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;            // 0 = local, 1 = fwd; meaningful in FLUSH
  logic   last_grant_q, last_grant_d;  // 0 = local, 1 = fwd
  logic   local_end, fwd_end;

  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    txTvalid    = 1'b0;
    txTlast     = 1'b0;
    txTdata     = '0;
    localTready = 1'b0;
    fwdTready   = 1'b0;
    grant       = 2'b00;
    unique case (state_q)
      IDLE: ;
      LOCAL: begin
        grant       = 2'b01;
        txTvalid    = localTvalid;
        txTlast     = localTlast;
        txTdata     = localTdata;
        localTready = txTready;
      end
      FWD: begin
        grant     = 2'b10;
        txTvalid  = fwdTvalid;
        txTlast   = fwdTlast;
        txTdata   = fwdTdata;
        fwdTready = txTready;
      end
      FLUSH: begin
        grant       = owner_q ? 2'b10 : 2'b01;
        localTready = ~owner_q;
        fwdTready   = owner_q;
      end
    endcase
  end

  assign local_end = localTvalid & localTready & localTlast;
  assign fwd_end   = fwdTvalid & fwdTready & fwdTlast;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (channelUp) begin
          if (localTvalid && (!fwdTvalid || last_grant_q)) begin
            state_d = LOCAL;
            owner_d = 1'b0;
          end else if (fwdTvalid) begin
            state_d = FWD;
            owner_d = 1'b1;
          end
        end
      end
      // A tlast completing in the same cycle the channel drops wins over FLUSH.
      LOCAL: begin
        if (local_end) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end else if (!channelUp) begin
          state_d = FLUSH;
        end
      end
      FWD: begin
        if (fwd_end) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end else if (!channelUp) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (owner_q ? fwd_end : local_end) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
    endcase
  end

`ifdef CELL_COMM_TX_STATS_EN
  logic [COUNTER_WIDTH-1:0] local_cnt_q, fwd_cnt_q, flush_cnt_q;

  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      local_cnt_q <= '0;
      fwd_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == LOCAL && local_end) local_cnt_q <= local_cnt_q + COUNTER_WIDTH'(1);
      if (state_q == FWD && fwd_end)     fwd_cnt_q   <= fwd_cnt_q + COUNTER_WIDTH'(1);
      if (state_q != FLUSH && state_d == FLUSH) flush_cnt_q <= flush_cnt_q + COUNTER_WIDTH'(1);
    end
  end

  assign localPktCount = local_cnt_q;
  assign fwdPktCount   = fwd_cnt_q;
  assign flushCount    = flush_cnt_q;
`else
  assign localPktCount = '0;
  assign fwdPktCount   = '0;
  assign flushCount    = '0;
`endif

endmodule

// File: tb/tb_cell_comm_tx_arbiter.sv
// Bench for cell_comm_tx_arbiter: directed vector table, reset sequences and a
// randomized run checked against a packet-rule reference model.
module tb_cell_comm_tx_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cu, lv, ll, fv, fl, tr;
  logic [DW-1:0] ld, fd;
  logic          lr, fr, txv, txl;
  logic [DW-1:0] txd;
  logic [1:0]    g;
  logic [CW-1:0] lcnt, fcnt, xcnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  cell_comm_tx_arbiter #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW)) dut (
    .auroraUserClk(clk), .auroraReset(rst), .channelUp(cu),
    .localTvalid(lv), .localTlast(ll), .localTdata(ld), .localTready(lr),
    .fwdTvalid(fv), .fwdTlast(fl), .fwdTdata(fd), .fwdTready(fr),
    .txTvalid(txv), .txTlast(txl), .txTdata(txd), .txTready(tr),
    .grant(g), .localPktCount(lcnt), .fwdPktCount(fcnt), .flushCount(xcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_counters(input int unsigned el, input int unsigned ef, input int unsigned ex);
`ifdef CELL_COMM_TX_STATS_EN
    chk("localPktCount", 64'(lcnt), 64'(el % (1 << CW)));
    chk("fwdPktCount",   64'(fcnt), 64'(ef % (1 << CW)));
    chk("flushCount",    64'(xcnt), 64'(ex % (1 << CW)));
`else
    chk("localPktCount", 64'(lcnt), 64'(el & 0));
    chk("fwdPktCount",   64'(fcnt), 64'(ef & 0));
    chk("flushCount",    64'(xcnt), 64'(ex & 0));
`endif
  endtask

  typedef struct packed {
    logic cu, lv, ll, fv, fl, tr;
    logic [1:0] g;
    logic tv, tl, lr, fr;
    logic [1:0] sel;  // expected txTdata: 0 = zero, 1 = local word, 2 = fwd word
  } vec_t;

  vec_t tbl[20];

  // Reference model: owner 0 none / 1 local / 2 fwd, flushing flag, last owner.
  int          m_own, m_last;
  bit          m_fl;
  int unsigned m_lc, m_fc, m_xc;

  initial begin
    logic [1:0]    eg;
    logic          ev, el, elr, efr, sv, sl, sr;
    logic [DW-1:0] ed;

    //           cu lv ll fv fl tr   g    tv tl lr fr sel
    tbl[0]  = '{1, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[1]  = '{1, 1, 0, 1, 0, 1, 2'b01, 1, 0, 1, 0, 2'd1};
    tbl[2]  = '{1, 1, 0, 1, 0, 1, 2'b01, 1, 0, 1, 0, 2'd1};
    tbl[3]  = '{1, 1, 0, 1, 0, 1, 2'b01, 1, 0, 1, 0, 2'd1};
    tbl[4]  = '{1, 1, 1, 1, 0, 1, 2'b01, 1, 1, 1, 0, 2'd1};
    tbl[5]  = '{1, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[6]  = '{1, 1, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 2'd2};
    tbl[7]  = '{1, 1, 0, 1, 0, 1, 2'b10, 1, 0, 0, 1, 2'd2};
    tbl[8]  = '{1, 1, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 2'd2};
    tbl[9]  = '{1, 1, 0, 1, 1, 1, 2'b10, 1, 1, 0, 1, 2'd2};
    tbl[10] = '{0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[11] = '{0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[12] = '{1, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[13] = '{0, 1, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0, 2'd1};
    tbl[14] = '{1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0, 2'd0};
    tbl[15] = '{0, 1, 1, 0, 0, 0, 2'b01, 0, 0, 1, 0, 2'd0};
    tbl[16] = '{1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[17] = '{1, 1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};
    tbl[18] = '{0, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0, 2'd1};
    tbl[19] = '{1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 2'd0};

    // Reset with both sources and the TX pushing: everything must stay quiet.
    rst = 1'b1; cu = 1'b1; lv = 1'b1; ll = 1'b0; fv = 1'b1; fl = 1'b0; tr = 1'b1;
    ld = 32'h1111_1111; fd = 32'h2222_2222;
    repeat (2) @(negedge clk);
    #1;
    chk("rst grant", 64'(g), 64'd0);
    chk("rst txTvalid", 64'(txv), 64'd0);
    chk("rst localTready", 64'(lr), 64'd0);
    chk("rst fwdTready", 64'(fr), 64'd0);
    chk_counters(0, 0, 0);
    @(negedge clk);
    rst = 1'b0; cu = 1'b0; lv = 1'b0; fv = 1'b0; tr = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      {cu, lv, ll, fv, fl, tr} = {tbl[i].cu, tbl[i].lv, tbl[i].ll, tbl[i].fv, tbl[i].fl, tbl[i].tr};
      ld = 32'h1000_0000 | 32'(i);
      fd = 32'h2000_0000 | 32'(i);
      #1;
      chk($sformatf("v%0d grant", i),    64'(g),   64'(tbl[i].g));
      chk($sformatf("v%0d txTvalid", i), 64'(txv), 64'(tbl[i].tv));
      chk($sformatf("v%0d txTlast", i),  64'(txl), 64'(tbl[i].tl));
      chk($sformatf("v%0d lready", i),   64'(lr),  64'(tbl[i].lr));
      chk($sformatf("v%0d fready", i),   64'(fr),  64'(tbl[i].fr));
      chk($sformatf("v%0d txTdata", i),  64'(txd),
          tbl[i].sel == 2'd1 ? 64'(ld) : tbl[i].sel == 2'd2 ? 64'(fd) : 64'd0);
    end
    chk_counters(2, 1, 1);

    // Reset in the middle of a local packet.
    @(negedge clk);
    cu = 1'b1; lv = 1'b1; ll = 1'b0; fv = 1'b0; tr = 1'b1;
    @(negedge clk);
    #1;
    chk("mid grant", 64'(g), 64'd1);
    chk("mid txTvalid", 64'(txv), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid rst grant", 64'(g), 64'd0);
    chk("mid rst txTvalid", 64'(txv), 64'd0);
    chk("mid rst lready", 64'(lr), 64'd0);
    chk("mid rst fready", 64'(fr), 64'd0);
    chk_counters(0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cu = 1'b0; lv = 1'b0; fv = 1'b0;
    #1;
    chk("post rst grant", 64'(g), 64'd0);

    // Randomized run against the reference model.
    m_own = 0; m_last = 2; m_fl = 1'b0; m_lc = 0; m_fc = 0; m_xc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cu = ($urandom_range(0, 99) < 88);
      lv = ($urandom_range(0, 9) < 6);
      ll = ($urandom_range(0, 3) == 0);
      fv = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 3) == 0);
      tr = ($urandom_range(0, 9) < 7);
      ld = $urandom;
      fd = $urandom;
      #1;
      eg = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
      ev = 1'b0; el = 1'b0; ed = '0; elr = 1'b0; efr = 1'b0;
      if (m_own != 0 && !m_fl) begin
        ev = (m_own == 1) ? lv : fv;
        el = (m_own == 1) ? ll : fl;
        ed = (m_own == 1) ? ld : fd;
        if (m_own == 1) elr = tr; else efr = tr;
      end else if (m_fl) begin
        if (m_own == 1) elr = 1'b1; else efr = 1'b1;
      end
      chk("rnd grant",    64'(g),   64'(eg));
      chk("rnd txTvalid", 64'(txv), 64'(ev));
      chk("rnd txTlast",  64'(txl), 64'(el));
      chk("rnd txTdata",  64'(txd), 64'(ed));
      chk("rnd lready",   64'(lr),  64'(elr));
      chk("rnd fready",   64'(fr),  64'(efr));
      chk_counters(m_lc, m_fc, m_xc);

      if (m_own == 0) begin
        if (cu) begin
          if (lv && fv) m_own = (m_last == 1) ? 2 : 1;
          else if (lv)  m_own = 1;
          else if (fv)  m_own = 2;
        end
      end else begin
        sv = (m_own == 1) ? lv : fv;
        sl = (m_own == 1) ? ll : fl;
        sr = m_fl ? 1'b1 : tr;
        if (sv && sr && sl) begin
          if (!m_fl) begin
            if (m_own == 1) m_lc++; else m_fc++;
          end
          m_last = m_own;
          m_own  = 0;
          m_fl   = 1'b0;
        end else if (!m_fl && !cu) begin
          m_fl = 1'b1;
          m_xc++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cell_comm_tx_arbiter.md
CELL_COMM_TX_ARBITER -- requirements
Module: cell_comm_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the AXIS data word on all three streams.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 16, the width of the statistics counters.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have these ports (name  direction  width  meaning):
  auroraUserClk  in  1  sole clock.
  auroraReset  in  1  asynchronous, active-high reset.
  channelUp  in  1  Aurora TX channel up, synchronous to auroraUserClk.
  localTvalid / localTlast  in  1  local FA packet stream (X/Y/S packet).
  localTdata  in  DATA_WIDTH  local packet word.
  localTready  out  1  local stream accepted.
  fwdTvalid / fwdTlast  in  1  forwarded-packet stream from the receive side.
  fwdTdata  in  DATA_WIDTH  forwarded packet word.
  fwdTready  out  1  forwarded stream accepted.
  txTvalid / txTlast  out  1  merged stream to the Aurora TX.
  txTdata  out  DATA_WIDTH  merged word.
  txTready  in  1  Aurora TX ready.
  grant  out  2  one-hot owner: bit0 = local, bit1 = fwd; 00 = none.
  localPktCount / fwdPktCount / flushCount  out  COUNTER_WIDTH  statistics.

Function
REQ-005 SHALL implement the states IDLE, LOCAL, FWD and FLUSH in a registered state machine.
REQ-006 In IDLE, all readies SHALL be 0, and txTvalid and grant SHALL be 0.
REQ-007 In IDLE with channelUp=1, if exactly one source has tvalid=1, the next state SHALL be that source's state.
REQ-008 In IDLE with channelUp=1 and both sources valid, arbitration SHALL be round-robin: grant goes to the source not granted last (lastGrant register).
REQ-009 In IDLE with channelUp=0, the block SHALL stay in IDLE and grant nothing; sources are held (tready=0).
REQ-010 In LOCAL/FWD, txTvalid/txTlast/txTdata SHALL combinationally equal the granted source's tvalid/tlast/tdata, and the granted source's tready SHALL equal txTready; the other source's tready SHALL be 0.
REQ-011 A packet SHALL never be interleaved: the grant changes only after the beat with tlast=1 is accepted.
REQ-012 On accepting a beat with tlast=1 (tvalid & tready & tlast), the state SHALL return to IDLE and lastGrant SHALL be updated; there is exactly one idle cycle between packets.
REQ-013 If channelUp=0 in LOCAL/FWD, the next state SHALL be FLUSH, keeping the same owner, in that same cycle's transition.
  In that cycle, the normal passthrough still applies (a beat may complete).
  If that beat carried tlast, the state SHALL go to IDLE instead and no flush is counted.
REQ-014 In FLUSH, txTvalid SHALL be 0 and the owner's tready SHALL be 1 (words discarded).
  The state SHALL exit to IDLE on the owner's accepted beat with tlast=1, regardless of channelUp.
REQ-015 grant SHALL reflect the owner in LOCAL, FWD and FLUSH, and be 00 in IDLE.
REQ-016 Word count, latency and data SHALL be unmodified in passthrough: zero-cycle combinational latency, with no buffering.

Reset
REQ-017 auroraReset SHALL asynchronously force state=IDLE, lastGrant=fwd (so local wins the first tie), and grant=00.
REQ-018 The counters SHALL reset to 0, and txTvalid, localTready and fwdTready SHALL be 0 while auroraReset=1.
REQ-019 Reset asserted mid-packet SHALL abandon the packet without emitting tlast; recovery is the sources' responsibility.

Configuration
REQ-020 With macro CELL_COMM_TX_STATS_EN defined:
  localPktCount/fwdPktCount SHALL increment on each accepted tlast beat forwarded to txT* from that source.
  flushCount SHALL increment on each entry to FLUSH.
  All counters SHALL wrap modulo 2^COUNTER_WIDTH.
REQ-021 Without CELL_COMM_TX_STATS_EN, all three counter outputs SHALL be constant 0 and no counter registers SHALL be synthesized; all other behaviour is identical.

Verification
REQ-022 Stimulus: local 4-word packet, fwd idle, txTready=1, channelUp=1 -> required response: grant=01 one cycle after localTvalid, 4 beats with tlast on the 4th, then IDLE, localPktCount=1.
REQ-023 Stimulus: both sources hold 4-word packets continuously after reset -> required response: order local, fwd, local, fwd; one idle cycle between packets; no interleaving.
REQ-024 Stimulus: txTready toggled 1,0,1,0 during a fwd packet -> required response: fwdTready mirrors txTready and data order is preserved.
REQ-025 Stimulus: channelUp drops after beat 2 of a 4-word local packet -> required response: FLUSH, txTvalid=0, localTready=1 until tlast, then IDLE, flushCount=1, localPktCount unchanged.
REQ-026 Stimulus: channelUp=0 with both sources valid -> required response: grant=00, both treadys 0; on channelUp=1, local granted first after reset.
REQ-027 Stimulus: auroraReset asserted mid-packet -> required response: outputs go idle immediately and the counters are 0; with the macro undefined, the counters read 0 throughout.
